// File: rtl/three_operand_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : three_operand_serial_subtractor
//  Purpose  : Bit-serial (LSB first) computation of a - b - c over WIDTH-bit
//             unsigned operands, with a 2-bit running borrow between bits.
//             One operation takes WIDTH RUN cycles followed by one DONE cycle.
//  Options  : define SUB_SATURATE_EN to clamp result to 0 on underflow
//             (borrow and underflow still report the true values).
//  Revision : 1.0 - initial release
// ============================================================================
module three_operand_serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       borrow,
  output logic             underflow
);

  // Bit index width; a 1-bit index is kept even when WIDTH=1.
  localparam int             IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;
  logic [1:0]       br;

  logic [2:0]       col;
  logic             bit_val;
  logic [1:0]       br_step;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign last_bit = (idx == LAST_IDX);

  // One bit column: biasing by 4 keeps d = a-b-c-br (-4..1) non-negative
  // (0..5). Bit 0 is the result bit, and the upper two bits give the
  // outgoing borrow as 2 - col[2:1].
  always_comb begin
    col      = 3'd4 + {2'b00, a_q[idx]} - {2'b00, b_q[idx]}
                    - {2'b00, c_q[idx]} - {1'b0, br};
    bit_val  = col[0];
    br_step  = 2'd2 - col[2:1];
    acc_next = acc;
    acc_next[idx] = bit_val;
  end

  // Operand capture, per-bit accumulation, and result update on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      acc       <= '0;
      idx       <= '0;
      br        <= 2'd0;
      result    <= '0;
      borrow    <= 2'd0;
      underflow <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      c_q <= c;
      acc <= '0;
      idx <= '0;
      br  <= 2'd0;
    end else if (state == S_RUN) begin
      acc <= acc_next;
      br  <= br_step;
      idx <= last_bit ? '0 : idx + 1'b1;
      if (last_bit) begin
        borrow    <= br_step;
        underflow <= (br_step != 2'd0);
`ifdef SUB_SATURATE_EN
        result    <= (br_step != 2'd0) ? '0 : acc_next;
`else
        result    <= acc_next;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_three_operand_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_three_operand_serial_subtractor
//  Purpose  : Directed self-checking bench for the serial subtractor, WIDTH=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_three_operand_serial_subtractor;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       borrow;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  three_operand_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .borrow    (borrow),
    .underflow (underflow)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and check the busy window and the done cycle.
  task automatic run_op(input string tag,
                        input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                        input logic [WIDTH-1:0] ci,
                        input logic [WIDTH-1:0] exp_res, input logic [1:0] exp_br,
                        input logic exp_uf);
    a = ai; b = bi; c = ci; start = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      check({tag, " done_low"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, " result"}, {29'd0, result}, {29'd0, exp_res});
    check({tag, " borrow"}, {30'd0, borrow}, {30'd0, exp_br});
    check({tag, " underflow"}, {31'd0, underflow}, {31'd0, exp_uf});
  endtask

  logic [WIDTH-1:0] sat_r2;
  logic [WIDTH-1:0] sat_r7;

  initial begin
`ifdef SUB_SATURATE_EN
    sat_r2 = 3'd0;
    sat_r7 = 3'd0;
`else
    sat_r2 = 3'd2;
    sat_r7 = 3'd7;
`endif
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", {29'd0, result}, 32'd0);
    check("reset borrow", {30'd0, borrow}, 32'd0);
    check("reset underflow", {31'd0, underflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", {31'd0, busy}, 32'd0);

    // 6 - 2 - 1 = 3
    run_op("op_6_2_1", 3'd6, 3'd2, 3'd1, 3'd3, 2'd0, 1'b0);
    @(negedge clk);
    check("op1 back_to_idle", {31'd0, busy | done}, 32'd0);

    // 0 - 7 - 7 = -14 = 2 - 2*8
    run_op("op_0_7_7", 3'd0, 3'd7, 3'd7, sat_r2, 2'd2, 1'b1);
    @(negedge clk);

    // 1 - 1 - 1 = -1 = 7 - 1*8, result held through IDLE
    run_op("op_1_1_1", 3'd1, 3'd1, 3'd1, sat_r7, 2'd1, 1'b1);
    repeat (2) @(negedge clk);
    check("held result", {29'd0, result}, {29'd0, sat_r7});
    check("held borrow", {30'd0, borrow}, 32'd1);
    check("held underflow", {31'd0, underflow}, 32'd1);
    run_op("op_5_5_0", 3'd5, 3'd5, 3'd0, 3'd0, 2'd0, 1'b0);
    @(negedge clk);

    // start held high: a new operation every WIDTH+1 cycles, operands
    // scrambled while the bits are being computed
    a = 3'd7; b = 3'd1; c = 3'd2; start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      for (int i = 0; i < WIDTH; i++) begin
        @(negedge clk);
        a = 3'd0; b = 3'd7; c = 3'd5;
        check("b2b busy", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      check("b2b done", {31'd0, done}, 32'd1);
      check("b2b result", {29'd0, result}, 32'd4);
      check("b2b underflow", {31'd0, underflow}, 32'd0);
      a = 3'd7; b = 3'd1; c = 3'd2;
      if (op == 2) start = 1'b0;
    end
    @(negedge clk);
    check("b2b idle", {31'd0, busy | done}, 32'd0);

    // Reset during the second RUN cycle
    a = 3'd1; b = 3'd2; c = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort run1 busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("abort run2 busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", {29'd0, result}, 32'd0);
    check("abort borrow", {30'd0, borrow}, 32'd0);
    check("abort underflow", {31'd0, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      check("no done after abort", {31'd0, done}, 32'd0);
    end
    run_op("op_3_0_0", 3'd3, 3'd0, 3'd0, 3'd3, 2'd0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
